// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC and buffers {PC, instr} pairs for decode.
// Optional FETCH_PERF_COUNTERS_EN adds FetchCount/FlushCount outputs.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Branch,
   input  logic [31:0] BranchTarget,
   output logic [31:0] Address,
   input  logic [31:0] ReadData,
   output logic [31:0] Instr,
   output logic [31:0] InstrPC,
   output logic        InstrValid,
   input  logic        InstrReady,
`ifdef FETCH_PERF_COUNTERS_EN
   output logic [31:0] FetchCount,
   output logic [31:0] FlushCount,
`endif
   output logic [31:0] PC
);

   logic [31:0] pc_buf  [2];
   logic [31:0] ins_buf [2];
   logic        head;
   logic        tail;
   logic [1:0]  count;
   logic        pop;
   logic        push;
   logic        unused_bits;

   assign unused_bits = ^BranchTarget[1:0];

   assign Address    = {2'b00, PC[31:2]};
   assign InstrValid = (count != 2'd0);
   assign pop        = InstrValid & InstrReady;
   assign push       = !Branch & ((count != 2'd2) | pop);

   // Head outputs come from the buffer registers, never from ReadData
   assign Instr   = InstrValid ? ins_buf[head] : 32'h0;
   assign InstrPC = InstrValid ? pc_buf[head]  : 32'h0;

   always_ff @(posedge clk) begin
      if (reset) begin
         PC    <= RESET_PC;
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else if (Branch) begin
         PC    <= {BranchTarget[31:2], 2'b00};
         head  <= 1'b0;
         tail  <= 1'b0;
         count <= 2'd0;
      end else begin
         if (push) begin
            pc_buf[tail]  <= PC;
            ins_buf[tail] <= ReadData;
            tail          <= ~tail;
            PC            <= PC + 32'd4;
         end
         if (pop) begin
            head <= ~head;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

`ifdef FETCH_PERF_COUNTERS_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         FetchCount <= 32'h0;
         FlushCount <= 32'h0;
      end else begin
         if (push) begin
            FetchCount <= FetchCount + 32'd1;
         end
         if (Branch) begin
            FlushCount <= FlushCount + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed plan steps plus random traffic against a
// queue-based reference model of the fetch buffer.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset, Branch, InstrReady;
   logic [31:0] BranchTarget;
   logic [31:0] Address, ReadData, Instr, InstrPC, PC;
   logic        InstrValid;

   logic        reset2, Branch2, InstrReady2;
   logic [31:0] BranchTarget2;
   logic [31:0] Address2, ReadData2, Instr2, InstrPC2, PC2;
   logic        InstrValid2;
`ifdef FETCH_PERF_COUNTERS_EN
   logic [31:0] FetchCount, FlushCount, FetchCount2, FlushCount2;
`endif

   logic [31:0] mem [64];
   assign ReadData  = mem[Address[5:0]];
   assign ReadData2 = mem[Address2[5:0]];

   always #5 clk = ~clk;

   fetch_unit dut (
      .clk(clk), .reset(reset), .Branch(Branch),
      .BranchTarget(BranchTarget), .Address(Address),
      .ReadData(ReadData), .Instr(Instr), .InstrPC(InstrPC),
      .InstrValid(InstrValid), .InstrReady(InstrReady),
`ifdef FETCH_PERF_COUNTERS_EN
      .FetchCount(FetchCount), .FlushCount(FlushCount),
`endif
      .PC(PC)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk(clk), .reset(reset2), .Branch(Branch2),
      .BranchTarget(BranchTarget2), .Address(Address2),
      .ReadData(ReadData2), .Instr(Instr2), .InstrPC(InstrPC2),
      .InstrValid(InstrValid2), .InstrReady(InstrReady2),
`ifdef FETCH_PERF_COUNTERS_EN
      .FetchCount(FetchCount2), .FlushCount(FlushCount2),
`endif
      .PC(PC2)
   );

   typedef struct {
      logic [31:0] pc;
      logic [31:0] ins;
   } ent_t;

   ent_t        q [$];
   logic [31:0] mpc;
   logic [31:0] mfetch, mflush;
   bit          known = 0;
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_model();
      if (known) begin
         chk("addr", Address, {2'b00, mpc[31:2]});
         chk("pc", PC, mpc);
         chk("valid", {31'h0, InstrValid}, {31'h0, q.size() != 0});
         chk("instr", Instr, q.size() != 0 ? q[0].ins : 32'h0);
         chk("instr_pc", InstrPC, q.size() != 0 ? q[0].pc : 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
         chk("fetch_cnt", FetchCount, mfetch);
         chk("flush_cnt", FlushCount, mflush);
`endif
      end
   endtask

   task automatic step_model();
      bit pop, push;
      if (reset) begin
         q.delete();
         mpc    = 32'h0;
         mfetch = 0;
         mflush = 0;
         known  = 1;
      end else begin
         pop  = (q.size() != 0) && InstrReady;
         push = !Branch && ((q.size() < 2) || pop);
         if (Branch) begin
            q.delete();
            mpc = {BranchTarget[31:2], 2'b00};
            mflush++;
         end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
               q.push_back('{pc: mpc, ins: mem[mpc[7:2]]});
               mpc = mpc + 32'd4;
               mfetch++;
            end
         end
      end
   endtask

   task automatic cyc();
      @(negedge clk);
      check_model();
      step_model();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      mem[0] = 32'hE3A00001;
      mem[1] = 32'hE2800002;
      reset = 1; Branch = 0; BranchTarget = 0; InstrReady = 1;
      reset2 = 1; Branch2 = 0; BranchTarget2 = 0; InstrReady2 = 0;

      // Straight-line fetch
      cyc();
      reset = 0;
      chk("tp1_addr", Address, 32'h0);
      chk("tp1_valid0", {31'h0, InstrValid}, 32'h0);
      cyc();
      chk("tp1_valid", {31'h0, InstrValid}, 32'h1);
      chk("tp1_instr", Instr, 32'hE3A00001);
      chk("tp1_ipc", InstrPC, 32'h0);
      chk("tp1_pc", PC, 32'h4);
      cyc();
      chk("tp2_instr", Instr, 32'hE2800002);
      chk("tp2_ipc", InstrPC, 32'h4);

      // Backpressure fills the buffer
      reset = 1;
      cyc();
      reset = 0; InstrReady = 0;
      repeat (4) cyc();
      chk("full_pc", PC, 32'h8);
      chk("full_addr", Address, 32'h2);
      chk("full_ipc", InstrPC, 32'h0);
      InstrReady = 1;
      cyc();
      chk("drain_ipc4", InstrPC, 32'h4);
      cyc();
      chk("drain_ipc8", InstrPC, 32'h8);
      cyc();
      chk("drain_ipc12", InstrPC, 32'hC);

      // Branch redirect
      Branch = 1; BranchTarget = 32'h14;
      cyc();
      Branch = 0;
      chk("br_valid", {31'h0, InstrValid}, 32'h0);
      chk("br_pc", PC, 32'h14);
      chk("br_addr", Address, 32'h5);
      cyc();
      chk("br_instr", Instr, mem[5]);
      chk("br_ipc", InstrPC, 32'h14);

      // Misaligned target
      Branch = 1; BranchTarget = 32'h17;
      cyc();
      Branch = 0;
      chk("mis_pc", PC, 32'h14);
      chk("mis_addr", Address, 32'h5);
      cyc();

      // Reset with a full buffer
      InstrReady = 0;
      repeat (3) cyc();
      chk("pre_rst_valid", {31'h0, InstrValid}, 32'h1);
      reset = 1;
      cyc();
      reset = 0;
      chk("rst_valid", {31'h0, InstrValid}, 32'h0);
      chk("rst_pc", PC, 32'h0);
`ifdef FETCH_PERF_COUNTERS_EN
      chk("rst_fetch_cnt", FetchCount, 32'h0);
      chk("rst_flush_cnt", FlushCount, 32'h0);
`endif

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         InstrReady   = ($urandom_range(0, 9) < 7);
         Branch       = ($urandom_range(0, 9) == 0);
         BranchTarget = $urandom;
         reset        = ($urandom_range(0, 49) == 0);
         cyc();
      end
      reset = 0; Branch = 0;
      cyc();

      // PC wrap from the top of the address space
      reset2 = 0;
      @(negedge clk);
      chk("wrap_pc0", PC2, 32'hFFFF_FFFC);
      chk("wrap_addr0", Address2, 32'h3FFF_FFFF);
      @(negedge clk);
      chk("wrap_pc", PC2, 32'h0);
      chk("wrap_addr", Address2, 32'h0);
      chk("wrap_ipc", InstrPC2, 32'hFFFF_FFFC);
      chk("wrap_instr", Instr2, mem[63]);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
